input_capture_port: RTL
=======================

INPUT_CAPTURE_PORT -- requirements
Module: input_capture_port

Interface
REQ-001 Parameter WIDTH, default 16: number of board input pins captured (1..32).
REQ-002 Parameter DEBOUNCE_CYCLES, default 50000: consecutive stable cycles required to accept a pin change (>=1).
REQ-003 Parameter EDGE_MODE, default 0: 0 = rising, 1 = falling, 2 = both edges captured.
REQ-004 Parameter INIT_LEVEL, default 0: reset value of every debounced bit (0 or 1, applied to all bits).
REQ-005 clk  in  1  single system clock; all logic on rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 avs_address  in  2  word address of the register accessed.
REQ-008 avs_read  in  1  read strobe, one cycle per access.
REQ-009 avs_write  in  1  write strobe, one cycle per access.
REQ-010 avs_writedata  in  32  write data.
REQ-011 avs_readdata  out  32  registered read data.
REQ-012 pins_in  in  WIDTH  asynchronous board inputs (switches/buttons).
REQ-013 irq  out  1  level interrupt to host.

Function
REQ-014 Each pins_in bit SHALL pass through a 2-flop synchronizer (sync) before any other use.
REQ-015 Each bit SHALL have an independent debounce counter; counter increments while sync differs from debounced, clears to 0 when equal.
REQ-016 Debounced bit SHALL take the sync value on the edge the counter reaches DEBOUNCE_CYCLES; counter clears on that edge.
REQ-017 Pin change to DATA update latency SHALL be exactly DEBOUNCE_CYCLES+2 clock edges; a pulse shorter than DEBOUNCE_CYCLES sync cycles SHALL produce no change.
REQ-018 Register map (word addresses): 0 DATA (RO, debounced); 1 IRQ_MASK (RW, WIDTH bits); 2 EDGE_CAPTURE (write-1-to-clear); 3 RAW (RO, sync value, undebounced).
REQ-019 An EDGE_CAPTURE bit SHALL set on the same edge its debounced bit changes in a direction selected by EDGE_MODE, and stay set until cleared.
REQ-020 Writing 1 to an EDGE_CAPTURE bit SHALL clear it; writing 0 SHALL leave it unchanged.
REQ-021 Simultaneous new edge and write-1-clear on the same bit SHALL leave the bit set (set wins).
REQ-022 Writes to addresses 0 and 3 SHALL be ignored; writedata bits above WIDTH SHALL be ignored.
REQ-023 avs_readdata SHALL be valid on the edge after avs_read (fixed read latency 1, no waitrequest) and SHALL hold its value when no read occurs.
REQ-024 Read bits above WIDTH SHALL return 0.
REQ-025 Read and write in the same cycle SHALL return the pre-write register value; the write takes effect.
REQ-026 irq SHALL equal OR of (EDGE_CAPTURE AND IRQ_MASK), derived from registers with no additional latency.

Reset
REQ-027 On reset: sync flops 0, debounce counters 0, debounced bits INIT_LEVEL, IRQ_MASK 0, EDGE_CAPTURE 0, avs_readdata 0, irq 0.
REQ-028 Reset asserted mid-debounce SHALL discard the partial count; no edge SHALL be captured during or on the reset edge.
REQ-029 After reset release, a pin level differing from INIT_LEVEL SHALL be treated as a normal change (captured per EDGE_MODE after DEBOUNCE_CYCLES+2).

Verification (bench uses WIDTH=16, DEBOUNCE_CYCLES=4, EDGE_MODE=0, INIT_LEVEL=0)
REQ-030 pins_in 0x0000 -> 0x0005 held -> DATA reads 0x00000005 after exactly 6 edges, EDGE_CAPTURE 0x00000005; read of DATA at edge 5 returns 0.
REQ-031 pins_in bit 3 pulsed high for 3 cycles -> DATA, EDGE_CAPTURE remain 0, RAW shows bit 3 during pulse.
REQ-032 IRQ_MASK=0x0004, EDGE_CAPTURE=0x0005 -> irq 1; write 0x0004 to addr 2 -> EDGE_CAPTURE 0x0001, irq 0 next cycle.
REQ-033 New rising edge on bit 0 coincides with write 0x0001 to addr 2 -> EDGE_CAPTURE bit 0 remains 1.
REQ-034 Write 0xFFFFFFFF to addr 0 and 3, then 0xFFFF1234 to addr 1 -> DATA/RAW unchanged, IRQ_MASK reads 0x00001234.
REQ-035 Reset asserted 2 cycles into a debounce of 0xFFFF -> all registers 0 next edge; after release with pins 0xFFFF held, DATA 0x0000FFFF after 6 edges.

Source files
------------

// File: rtl/input_capture_port.sv
// rtl/input_capture_port.sv - debounced board-input capture port with edge latching, irq and a 4-word register window
module input_capture_port #(
    parameter int WIDTH           = 16,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int EDGE_MODE       = 0,
    parameter int INIT_LEVEL      = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       avs_address,
    input  logic             avs_read,
    input  logic             avs_write,
    input  logic [31:0]      avs_writedata,
    output logic [31:0]      avs_readdata,
    input  logic [WIDTH-1:0] pins_in,
    output logic             irq
);

    localparam int               CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]    CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [WIDTH-1:0] DEB_INIT = {WIDTH{INIT_LEVEL[0]}};

    logic [WIDTH-1:0] sync1_q, sync2_q;
    logic [WIDTH-1:0] deb_q, deb_d;
    logic [CW-1:0]    cnt_q [WIDTH];
    logic [CW-1:0]    cnt_d [WIDTH];
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] ecap_q, ecap_d;
    logic [31:0]      rdata_q, rdata_d;
    logic [WIDTH-1:0] edges;
    logic [WIDTH-1:0] clr;
    logic [31:0]      rd_word;
    logic             wdata_unused;

    assign wdata_unused = ^avs_writedata;

    // Counter runs only while the synchronized pin disagrees with the accepted level.
    always_comb begin
        deb_d = deb_q;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != deb_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    deb_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
        end
    end

    always_comb begin
        if (EDGE_MODE == 0) begin
            edges = deb_d & ~deb_q;
        end else if (EDGE_MODE == 1) begin
            edges = ~deb_d & deb_q;
        end else begin
            edges = deb_d ^ deb_q;
        end
    end

    // A new edge outranks a simultaneous write-1-to-clear.
    always_comb begin
        clr    = (avs_write && avs_address == 2'd2) ? avs_writedata[WIDTH-1:0] : '0;
        ecap_d = (ecap_q & ~clr) | edges;
        mask_d = (avs_write && avs_address == 2'd1) ? avs_writedata[WIDTH-1:0] : mask_q;
    end

    always_comb begin
        rd_word = '0;
        case (avs_address)
            2'd0:    rd_word[WIDTH-1:0] = deb_q;
            2'd1:    rd_word[WIDTH-1:0] = mask_q;
            2'd2:    rd_word[WIDTH-1:0] = ecap_q;
            default: rd_word[WIDTH-1:0] = sync2_q;
        endcase
        rdata_d = avs_read ? rd_word : rdata_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            deb_q   <= DEB_INIT;
            mask_q  <= '0;
            ecap_q  <= '0;
            rdata_q <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q <= pins_in;
            sync2_q <= sync1_q;
            deb_q   <= deb_d;
            mask_q  <= mask_d;
            ecap_q  <= ecap_d;
            rdata_q <= rdata_d;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign avs_readdata = rdata_q;
    assign irq          = |(ecap_q & mask_q);

endmodule
